// File: rtl/s2c_call_sched.sv
// s2c_call_sched: shares one s2cif function-call channel between NREQ requesters using
// round-robin arbitration, one call in flight, sticky end-of-data flags and a result timeout.
module s2c_call_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int TMO  = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [NREQ*8-1:0] req_id_i,
  input  logic [NREQ*8-1:0] req_fn_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [NREQ-1:0]   rsp_valid_o,
  output logic [31:0]       rsp_ret_o,
  output logic [DW-1:0]     rsp_data_o,
  output logic              call_valid_o,
  input  logic              call_ready_i,
  output logic [7:0]        call_id_o,
  output logic [7:0]        call_fn_o,
  input  logic              cret_valid_i,
  input  logic [31:0]       cret_ret_i,
  input  logic [DW-1:0]     cret_data_i,
  output logic [NREQ-1:0]   done_o,
  output logic              busy_o
);

  localparam int GW = $clog2(NREQ);
  localparam int TW = $clog2(TMO + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [GW-1:0] LAST_RST = GW'(NREQ - 1);
  localparam logic [TW-1:0] TMO_V    = TW'(TMO);
  localparam logic [31:0]   RET_EOD  = 32'hFFFF_FFFF;
  localparam logic [31:0]   RET_TMO  = 32'hFFFF_FFFE;

  function automatic logic [NREQ-1:0] onehot(input logic [GW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = {NREQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  logic [1:0]      state_q, state_d;
  logic [GW-1:0]   last_q, last_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [7:0]      call_id_q, call_id_d;
  logic [7:0]      call_fn_q, call_fn_d;
  logic            call_valid_q, call_valid_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_ret_q, rsp_ret_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q;
  logic            run_q;

  logic            gnt_found_s;
  logic [GW-1:0]   gnt_idx_s;
  logic [GW:0]     rr_sum_s;
  logic [GW-1:0]   rr_cand_s;
  logic            rr_take_s;
  logic [NREQ-1:0] req_ready_s;

  // Round-robin search starting one past the last served requester.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = {GW{1'b0}};
    rr_sum_s    = {(GW+1){1'b0}};
    rr_cand_s   = {GW{1'b0}};
    rr_take_s   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      rr_sum_s    = {1'b0, last_q} + (GW+1)'(k + 1);
      rr_cand_s   = (rr_sum_s >= (GW+1)'(NREQ)) ? GW'(rr_sum_s - (GW+1)'(NREQ)) : GW'(rr_sum_s);
      rr_take_s   = req_valid_i[rr_cand_s] & ~gnt_found_s;
      gnt_idx_s   = rr_take_s ? rr_cand_s : gnt_idx_s;
      gnt_found_s = gnt_found_s | rr_take_s;
    end
  end

  // Next-state and output-register logic of the call FSM.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    call_id_d    = call_id_q;
    call_fn_d    = call_fn_q;
    call_valid_d = call_valid_q;
    timer_d      = timer_q;
    rsp_valid_d  = {NREQ{1'b0}};
    rsp_ret_d    = rsp_ret_q;
    rsp_data_d   = rsp_data_q;
    done_d       = done_q;
    req_ready_s  = {NREQ{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (run_q && gnt_found_s) begin
          req_ready_s = onehot(gnt_idx_s);
          gnt_d       = gnt_idx_s;
          call_id_d   = req_id_i[{gnt_idx_s, 3'b000} +: 8];
          call_fn_d   = req_fn_i[{gnt_idx_s, 3'b000} +: 8];
          // A requester that already hit end-of-data is answered locally.
          if (done_q[gnt_idx_s]) begin
            state_d     = S_RESP;
            rsp_valid_d = onehot(gnt_idx_s);
            rsp_ret_d   = RET_EOD;
            rsp_data_d  = {DW{1'b0}};
          end else begin
            state_d      = S_ISSUE;
            call_valid_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (call_ready_i) begin
          call_valid_d = 1'b0;
          timer_d      = {TW{1'b0}};
          state_d      = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (cret_valid_i) begin
          state_d     = S_RESP;
          rsp_valid_d = onehot(gnt_q);
          rsp_ret_d   = cret_ret_i;
          rsp_data_d  = cret_data_i;
        end else if (timer_q == TMO_V) begin
          state_d     = S_RESP;
          rsp_valid_d = onehot(gnt_q);
          rsp_ret_d   = RET_TMO;
          rsp_data_d  = {DW{1'b0}};
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESP: begin
        done_d  = done_q | ({NREQ{rsp_ret_q[31]}} & onehot(gnt_q));
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; run_q holds off arbitration until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_q       <= LAST_RST;
      gnt_q        <= {GW{1'b0}};
      call_id_q    <= 8'd0;
      call_fn_q    <= 8'd0;
      call_valid_q <= 1'b0;
      timer_q      <= {TW{1'b0}};
      rsp_valid_q  <= {NREQ{1'b0}};
      rsp_ret_q    <= 32'd0;
      rsp_data_q   <= {DW{1'b0}};
      done_q       <= {NREQ{1'b0}};
      busy_q       <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      call_id_q    <= call_id_d;
      call_fn_q    <= call_fn_d;
      call_valid_q <= call_valid_d;
      timer_q      <= timer_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_ret_q    <= rsp_ret_d;
      rsp_data_q   <= rsp_data_d;
      done_q       <= done_d;
      busy_q       <= (state_d != S_IDLE);
      run_q        <= 1'b1;
    end
  end

  assign req_ready_o  = req_ready_s;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_ret_o    = rsp_ret_q;
  assign rsp_data_o   = rsp_data_q;
  assign call_valid_o = call_valid_q;
  assign call_id_o    = call_id_q;
  assign call_fn_o    = call_fn_q;
  assign done_o       = done_q;
  assign busy_o       = busy_q;

endmodule
